// File: rtl/rgb_stream_packer_if.sv
// Pixel-side and 32-bit stream-side bundles for rgb_stream_packer.
// The pixel source drives master on rgb_pixel_if; the packer drives master on rgb_stream_packer_if.
interface rgb_pixel_if;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       valid;
    logic       sof;
    logic       eol;
    logic       in_stream_ready;

    // A pixel transfers on any rising edge where valid && in_stream_ready.
    modport master (output r, g, b, valid, sof, eol, input in_stream_ready);
    modport slave  (input r, g, b, valid, sof, eol, output in_stream_ready);
endinterface

interface rgb_stream_packer_if;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;

    modport master (output out_stream_tdata, out_stream_tkeep, out_stream_tlast,
                    output out_stream_tuser, out_stream_tvalid, input out_stream_tready);
    modport slave  (input out_stream_tdata, out_stream_tkeep, out_stream_tlast,
                    input out_stream_tuser, out_stream_tvalid, output out_stream_tready);
endinterface

// File: rtl/rgb_stream_packer.sv
// Packs RGB888 pixels 4-into-3 onto a 32-bit AXI4-Stream with sof->tuser, eol->tlast.
// Optional macro RGB_PACKER_TKEEP_EN: padded line-end words carry a partial tkeep.
module rgb_stream_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic aclk,
    input  logic areset,
    rgb_pixel_if.slave          pix,
    rgb_stream_packer_if.master axis,
    output logic                dbg_state
);

`ifdef RGB_PACKER_TKEEP_EN
    localparam bit KEEP_EN = 1'b1;
`else
    localparam bit KEEP_EN = 1'b0;
`endif

    localparam logic [3:0] KEEP_1 = KEEP_EN ? 4'b0001 : 4'hF;
    localparam logic [3:0] KEEP_2 = KEEP_EN ? 4'b0011 : 4'hF;
    localparam logic [3:0] KEEP_3 = KEEP_EN ? 4'b0111 : 4'hF;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [23:0] resid_q, resid_d;
    logic        sof_pend_q, sof_pend_d;
    logic [31:0] flush_data_q, flush_data_d;
    logic [3:0]  flush_keep_q, flush_keep_d;

    logic [31:0] o_data;
    logic [3:0]  o_keep;
    logic        o_last, o_user, o_valid;

    logic        reg_free, in_ready, accept, load_word;
    logic [31:0] w_data;
    logic [3:0]  w_keep;
    logic        w_last, w_user;

    // Output register may take a new word when empty or when its word leaves this edge.
    assign reg_free  = !o_valid || axis.out_stream_tready;
    assign in_ready  = !areset && (state_q == RUN) && reg_free;
    assign accept    = pix.valid && in_ready;
    assign dbg_state = state_q;

    assign pix.in_stream_ready    = in_ready;
    assign axis.out_stream_tdata  = o_data;
    assign axis.out_stream_tkeep  = o_keep;
    assign axis.out_stream_tlast  = o_last;
    assign axis.out_stream_tuser  = o_user;
    assign axis.out_stream_tvalid = o_valid;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        resid_d      = resid_q;
        sof_pend_d   = sof_pend_q;
        flush_data_d = flush_data_q;
        flush_keep_d = flush_keep_q;
        load_word    = 1'b0;
        w_data       = 32'h0;
        w_keep       = 4'hF;
        w_last       = 1'b0;
        w_user       = 1'b0;

        if (state_q == FLUSH) begin
            if (reg_free) begin
                load_word  = 1'b1;
                w_data     = flush_data_q;
                w_keep     = flush_keep_q;
                w_last     = 1'b1;
                w_user     = sof_pend_q;
                sof_pend_d = 1'b0;
                state_d    = RUN;
            end
        end else if (accept) begin
            // Residual bytes sit from bit 0 upward; phase says how many are left over.
            case (phase_q)
                2'd0: begin
                    resid_d = {pix.b, pix.g, pix.r};
                    phase_d = 2'd1;
                    if (pix.eol) begin
                        load_word = 1'b1;
                        w_data    = {PAD_BYTE, pix.b, pix.g, pix.r};
                        w_keep    = KEEP_3;
                        w_last    = 1'b1;
                    end
                end
                2'd1: begin
                    load_word = 1'b1;
                    w_data    = {pix.r, resid_q[23:0]};
                    resid_d   = {8'h00, pix.b, pix.g};
                    phase_d   = 2'd2;
                    if (pix.eol) begin
                        state_d      = FLUSH;
                        flush_data_d = {PAD_BYTE, PAD_BYTE, pix.b, pix.g};
                        flush_keep_d = KEEP_2;
                    end
                end
                2'd2: begin
                    load_word = 1'b1;
                    w_data    = {pix.g, pix.r, resid_q[15:0]};
                    resid_d   = {16'h0000, pix.b};
                    phase_d   = 2'd3;
                    if (pix.eol) begin
                        state_d      = FLUSH;
                        flush_data_d = {PAD_BYTE, PAD_BYTE, PAD_BYTE, pix.b};
                        flush_keep_d = KEEP_1;
                    end
                end
                default: begin
                    load_word = 1'b1;
                    w_data    = {pix.b, pix.g, pix.r, resid_q[7:0]};
                    w_last    = pix.eol;
                    resid_d   = 24'h0;
                    phase_d   = 2'd0;
                end
            endcase

            if (pix.eol) begin
                phase_d = 2'd0;
                resid_d = 24'h0;
            end

            // A word leaving on the same accept as sof carries tuser itself.
            if (load_word) begin
                w_user     = sof_pend_q || pix.sof;
                sof_pend_d = 1'b0;
            end else if (pix.sof) begin
                sof_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= RUN;
            phase_q      <= 2'd0;
            resid_q      <= 24'h0;
            sof_pend_q   <= 1'b0;
            flush_data_q <= 32'h0;
            flush_keep_q <= 4'hF;
            o_data       <= 32'h0;
            o_keep       <= 4'hF;
            o_last       <= 1'b0;
            o_user       <= 1'b0;
            o_valid      <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            resid_q      <= resid_d;
            sof_pend_q   <= sof_pend_d;
            flush_data_q <= flush_data_d;
            flush_keep_q <= flush_keep_d;
            if (load_word) begin
                o_data  <= w_data;
                o_keep  <= w_keep;
                o_last  <= w_last;
                o_user  <= w_user;
                o_valid <= 1'b1;
            end else if (axis.out_stream_tready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rgb_stream_packer.md
# rgb_stream_packer

- Converts the pixel generator's per-pixel RGB888 output (8-bit r/g/b, valid, sof, eol) into a 32-bit AXI4-Stream for the VDMA/video path.
- Packs 4 pixels into 3 words, marks start-of-frame on tuser and end-of-line on tlast, and zero-pads a partial word at line end.
- Sits directly downstream of the pixel generator.
- Backpressure from the stream propagates to the generator through in_stream_ready.

## Interface
- PAD_BYTE, 8'h00, value written into unused byte lanes of a flushed partial word.
- aclk  in  1  sole clock; all logic rising-edge.
- areset  in  1  asynchronous, active-high reset.
- r, g, b  in  8 each  pixel colour bytes.
- valid  in  1  pixel present; accepted when valid && in_stream_ready.
- sof  in  1  qualifies the accepted pixel as first pixel of a frame.
- eol  in  1  qualifies the accepted pixel as last pixel of a line.
- in_stream_ready  out  1  block can accept a pixel this cycle.
- out_stream_tdata  out  32  packed bytes; stream byte k occupies bits [8k+7:8k].
- out_stream_tkeep  out  4  valid byte lanes.
- out_stream_tlast  out  1  last word of a line.
- out_stream_tuser  out  1  first word of a frame.
- out_stream_tvalid  out  1  word present.
- out_stream_tready  in  1  sink accepts word.

## Operation
- Per-pixel byte order on the stream is r, g, b (r at the lowest stream byte).
- A 2-bit phase holds pixels accepted since the last alignment, mod 4. A 24-bit residual holds leftover bytes.
- Residual byte count by phase: 0, 3, 2, 1.
- Accept at phase 0 (no eol): store 3 bytes; no word emitted.
- Accept at phases 1, 2 or 3: complete and emit one full word (tkeep 4'hF); keep the remainder; phase+1 mod 4.
- eol handling, by phase before the accept:
  - p0: emit one word {PAD, b, g, r}, tkeep 4'b0111, tlast=1.
  - p1: emit a full word (tlast=0), then enter FLUSH and emit {PAD, PAD, b, g} with tkeep 4'b0011, tlast=1.
  - p2: emit a full word (tlast=0), then FLUSH emits {PAD×3, b}, tkeep 4'b0001, tlast=1.
  - p3: emit one full word, tlast=1.
  - Phase returns to 0 and the residual clears after every eol.
- sof sets a pending flag on accept. The next emitted word carries tuser=1 and clears the flag.
  - If sof arrives at a nonzero phase, no realignment occurs; tuser goes on the next emitted word.
- State machine:
  - RUN: normal operation.
  - FLUSH: one pending padded word; in_stream_ready=0.
  - FLUSH → RUN when the padded word loads into the output register.
- Reset or areset mid-line: drop the residual, pending sof and any held word. No partial word is emitted.

## Timing
- Output register, one deep. It holds tdata/tkeep/tlast/tuser/tvalid stable while tvalid && !tready.
- in_stream_ready = (state==RUN) && (!out_stream_tvalid || out_stream_tready). It is combinational from tready.
- Latency: a word-producing accept in cycle N gives tvalid=1 in cycle N+1.
- FLUSH word loads in the first cycle the register is free after the eol accept.
- Throughput: 1 pixel/cycle with tready held high; each p1/p2 eol costs exactly 1 extra cycle.
- Reset values: tvalid 0, tdata 0, tkeep 4'hF, tlast 0, tuser 0, state RUN, phase 0, sof pending 0.
- in_stream_ready is 0 while areset is high and 1 in the first cycle after release (given tvalid=0).
- A simultaneous word transfer and new word-producing accept reloads the register the same edge, with no bubble.

## Configuration
- RGB_PACKER_TKEEP_EN defined: padded words carry partial tkeep as specified above.
- RGB_PACKER_TKEEP_EN undefined: tkeep is constant 4'hF. Pad lanes still hold PAD_BYTE, and tlast placement is unchanged.

## Test plan
- Basic packing: sof on p0, pixels (01,02,03), (11,12,13), (21,22,23), (31,32,33) with eol on the 4th, tready=1 → words 0x11030201 (tuser=1), 0x22211312, 0x33323123 (tlast=1), all tkeep F.
- p0 eol: single pixel (AA,BB,CC) with eol → 0x00CCBBAA, tkeep 0111, tlast=1. Without RGB_PACKER_TKEEP_EN, tkeep is F.
- p1 eol: two pixels (01,02,03), (11,12,13) with eol on the 2nd → 0x11030201 (tlast 0), then 0x00001312 with tkeep 0011 and tlast=1. in_stream_ready is low for 1 cycle.
- Backpressure: hold tready=0 for 5 cycles mid-line → tdata stable, in_stream_ready=0, no pixel lost. Word order is identical to the tready=1 run.
- Async reset: assert areset at phase 2 with tvalid=1 → tvalid drops immediately. The next line starting with sof produces correctly aligned words with tuser=1 on the first word.
- Full line: 640 pixels, eol on the last, random tready → 480 words, tlast only on word 480, tkeep F throughout.
